// File: rtl/npc_btb_unit_if.sv
// Pipeline-side bundle of the next-PC unit: fetch PC/prediction out, EX/ID redirect info in.
// slave = the next-PC unit, master = the pipeline driving it.
interface npc_btb_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_f;
    logic [XLEN-1:0] pc_f;
    logic            pred_taken_f;
    logic            jal_d;
    logic [XLEN-1:0] jal_target_d;
    logic            br_valid_e;
    logic            br_taken_e;
    logic [XLEN-1:0] br_target_e;
    logic [XLEN-1:0] pc_e;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;
    logic            jalr_e;
    logic [XLEN-1:0] jalr_target_e;
    logic            flush_e_req;
    logic            flush_d_req;

    modport slave (
        input  stall_f, jal_d, jal_target_d, br_valid_e, br_taken_e, br_target_e,
               pc_e, pred_taken_e, pred_target_e, jalr_e, jalr_target_e,
        output pc_f, pred_taken_f, flush_e_req, flush_d_req
    );

    modport master (
        output stall_f, jal_d, jal_target_d, br_valid_e, br_taken_e, br_target_e,
               pc_e, pred_taken_e, pred_target_e, jalr_e, jalr_target_e,
        input  pc_f, pred_taken_f, flush_e_req, flush_d_req
    );
endinterface

// File: rtl/npc_btb_unit.sv
// Fetch PC register plus direct-mapped BTB with saturating direction counters.
// Optional NPC_PERF_EN adds branch / mispredict performance counters.
module npc_btb_unit #(
    parameter int              XLEN         = 32,
    parameter int              BTB_ENTRIES  = 64,
    parameter int              CNT_W        = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               rst,
    npc_btb_unit_if.slave      npc
`ifdef NPC_PERF_EN
    ,
    output logic [31:0]        perf_br_cnt,
    output logic [31:0]        perf_mispred_cnt
`endif
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic [XLEN-1:0]  pc_f_q, pc_f_d;
    logic             valid_q  [BTB_ENTRIES];
    logic             valid_d  [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]  target_q [BTB_ENTRIES];
    logic [XLEN-1:0]  target_d [BTB_ENTRIES];
    logic [CNT_W-1:0] cnt_q    [BTB_ENTRIES];
    logic [CNT_W-1:0] cnt_d    [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e, pred_taken_f, mispredict, flush_e;
    logic [XLEN-1:0]  fix_pc;

    assign idx_f = pc_f_q[IDX_W+1:2];
    assign tag_f = pc_f_q[XLEN-1:IDX_W+2];
    assign idx_e = npc.pc_e[IDX_W+1:2];
    assign tag_e = npc.pc_e[XLEN-1:IDX_W+2];

    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign pred_taken_f = hit_f && cnt_q[idx_f][CNT_W-1];

    // Wrong direction, or right "taken" direction with a stale target.
    assign mispredict = npc.br_valid_e &&
                        ((npc.br_taken_e != npc.pred_taken_e) ||
                         (npc.br_taken_e && npc.pred_taken_e &&
                          (npc.br_target_e != npc.pred_target_e)));
    assign fix_pc  = npc.br_taken_e ? npc.br_target_e : npc.pc_e + XLEN'(4);
    assign flush_e = mispredict || npc.jalr_e;

    assign npc.pc_f         = pc_f_q;
    assign npc.pred_taken_f = pred_taken_f;
    assign npc.flush_e_req  = flush_e;
    assign npc.flush_d_req  = npc.jal_d && !flush_e;

    always_comb begin
        pc_f_d   = pc_f_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;

        if (mispredict)             pc_f_d = fix_pc;
        else if (npc.jalr_e)        pc_f_d = npc.jalr_target_e;
        else if (npc.jal_d)         pc_f_d = npc.jal_target_d;
        else if (npc.stall_f)       pc_f_d = pc_f_q;
        else if (pred_taken_f)      pc_f_d = target_q[idx_f];
        else                        pc_f_d = pc_f_q + XLEN'(4);

        // Training ignores stall_f: the EX result is final regardless of IF state.
        if (npc.br_valid_e) begin
            if (npc.br_taken_e) begin
                if (hit_e) begin
                    target_d[idx_e] = npc.br_target_e;
                    if (cnt_q[idx_e] != CNT_MAX) cnt_d[idx_e] = cnt_q[idx_e] + CNT_W'(1);
                end else begin
                    valid_d[idx_e]  = 1'b1;
                    tag_d[idx_e]    = tag_e;
                    target_d[idx_e] = npc.br_target_e;
                    cnt_d[idx_e]    = CNT_WT;
                end
            end else if (hit_e && (cnt_q[idx_e] != '0)) begin
                cnt_d[idx_e] = cnt_q[idx_e] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_VECTOR;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else begin
            pc_f_q   <= pc_f_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef NPC_PERF_EN
    logic [31:0] perf_br_q, perf_br_d, perf_mis_q, perf_mis_d;

    always_comb begin
        perf_br_d  = perf_br_q  + (npc.br_valid_e ? 32'd1 : 32'd0);
        perf_mis_d = perf_mis_q + (mispredict     ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_q  <= '0;
            perf_mis_q <= '0;
        end else begin
            perf_br_q  <= perf_br_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    assign perf_br_cnt      = perf_br_q;
    assign perf_mispred_cnt = perf_mis_q;
`endif
endmodule
